// File: rtl/chan_ctrl_pkg.sv
// ============================================================================
// Module : chan_ctrl_pkg
// Desc   : Shared field codes and channel state encoding for chan_ctrl_bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package chan_ctrl_pkg;

   localparam logic [2:0] FLD_FRAME  = 3'd0;
   localparam logic [2:0] FLD_BLANK  = 3'd1;
   localparam logic [2:0] FLD_RBEG   = 3'd2;
   localparam logic [2:0] FLD_REND   = 3'd3;
   localparam logic [2:0] FLD_CLR    = 3'd4;
   localparam logic [2:0] FLD_ERRCLR = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/chan_ctrl_bank_if.sv
// ============================================================================
// Module : chan_ctrl_bank_if
// Desc   : Host write/commit bus into the channel control register bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface chan_ctrl_bank_if #(
   parameter int CH_W = 2
);
   logic            cs_n;
   logic [CH_W-1:0] wr_ch;
   logic [2:0]      wr_field;
   logic [31:0]     wr_data;
   logic            commit;

   modport master (output cs_n, wr_ch, wr_field, wr_data, commit);
   modport slave  (input  cs_n, wr_ch, wr_field, wr_data, commit);
endinterface

`default_nettype wire

// File: rtl/chan_ctrl_fsm.sv
// ============================================================================
// Module : chan_ctrl_fsm
// Desc   : Per-channel IDLE/CLEAR/RUN sequencer driving fifo_clr and run.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module chan_ctrl_fsm
   import chan_ctrl_pkg::*;
#(
   parameter int CLR_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic stop,
   input  logic clr_req,
   output logic fifo_clr,
   output logic run,
   output logic busy,
   output logic idle
);

   localparam int                 c_cnt_w = $clog2(CLR_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLR_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   chan_state_e        r_state;
   chan_state_e        w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic               r_ret;
   logic               w_ret_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ret   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ret   <= w_ret_nxt;
      end
   end

   // Stop outranks every transition, including a clear request issued in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ret_nxt   = r_ret;
      fifo_clr    = 1'b0;
      run         = 1'b0;
      busy        = 1'b1;
      idle        = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            idle = 1'b1;
            if (!stop && (start || clr_req)) begin
               w_state_nxt = CLEAR;
               w_cnt_nxt   = '0;
               w_ret_nxt   = start;
            end
         end
         CLEAR: begin
            fifo_clr = 1'b1;
            if (stop) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == c_last) begin
               w_state_nxt = r_ret ? RUN : IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         RUN: begin
            run = 1'b1;
            if (stop) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/chan_ctrl_bank.sv
// ============================================================================
// Module : chan_ctrl_bank
// Desc   : Shadow/active per-channel control registers with validated commit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module chan_ctrl_bank
   import chan_ctrl_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int LEN_W      = 16,
   parameter int ADDR_W     = 16,
   parameter int CLR_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   chan_ctrl_bank_if.slave          host,
   input  logic [NUM_CH-1:0]        start,
   input  logic [NUM_CH-1:0]        stop,
   output logic [NUM_CH*LEN_W-1:0]  frame_len,
   output logic [NUM_CH*LEN_W-1:0]  blank_len,
   output logic [NUM_CH*ADDR_W-1:0] rdaddr_begin,
   output logic [NUM_CH*ADDR_W-1:0] rdaddr_end,
   output logic [NUM_CH-1:0]        fifo_clr,
   output logic [NUM_CH-1:0]        run,
   output logic [NUM_CH-1:0]        cfg_err,
   output logic                     busy
);

   logic [NUM_CH-1:0] w_busy;
   logic              w_unused_data;

   assign w_unused_data = ^host.wr_data;
   assign busy          = |w_busy;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic              w_sel;
      logic              w_wr;
      logic              w_com;
      logic              w_clr_req;
      logic              w_idle;
      logic [LEN_W-1:0]  r_sh_frame;
      logic [LEN_W-1:0]  r_sh_blank;
      logic [ADDR_W-1:0] r_sh_rbeg;
      logic [ADDR_W-1:0] r_sh_rend;
      logic [LEN_W-1:0]  r_act_frame;
      logic [LEN_W-1:0]  r_act_blank;
      logic [ADDR_W-1:0] r_act_rbeg;
      logic [ADDR_W-1:0] r_act_rend;
      logic              r_cfg_err;

      // Channel indices at or above NUM_CH never match, so those writes drop out.
      assign w_sel     = (host.wr_ch == CH_W'(i));
      assign w_wr      = !host.cs_n && w_sel;
      assign w_com     = host.commit && w_sel;
      assign w_clr_req = w_wr && (host.wr_field == FLD_CLR);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_sh_frame  <= '0;
            r_sh_blank  <= '0;
            r_sh_rbeg   <= '0;
            r_sh_rend   <= '0;
            r_act_frame <= '0;
            r_act_blank <= '0;
            r_act_rbeg  <= '0;
            r_act_rend  <= '0;
            r_cfg_err   <= 1'b0;
         end else begin
            if (w_wr) begin
               case (host.wr_field)
                  FLD_FRAME:  r_sh_frame <= host.wr_data[LEN_W-1:0];
                  FLD_BLANK:  r_sh_blank <= host.wr_data[LEN_W-1:0];
                  FLD_RBEG:   r_sh_rbeg  <= host.wr_data[ADDR_W-1:0];
                  FLD_REND:   r_sh_rend  <= host.wr_data[ADDR_W-1:0];
                  FLD_ERRCLR: if (host.wr_data[0]) r_cfg_err <= 1'b0;
                  default:    ;
               endcase
            end
            // Commit samples the shadow before any same-edge write lands.
            if (w_com) begin
               if (w_idle && (r_sh_rbeg <= r_sh_rend)) begin
                  r_act_frame <= r_sh_frame;
                  r_act_blank <= r_sh_blank;
                  r_act_rbeg  <= r_sh_rbeg;
                  r_act_rend  <= r_sh_rend;
               end else begin
                  r_cfg_err <= 1'b1;
               end
            end
         end
      end

      chan_ctrl_fsm #(
         .CLR_CYCLES (CLR_CYCLES)
      ) u_fsm (
         .clk      (clk),
         .reset_n  (reset_n),
         .start    (start[i]),
         .stop     (stop[i]),
         .clr_req  (w_clr_req),
         .fifo_clr (fifo_clr[i]),
         .run      (run[i]),
         .busy     (w_busy[i]),
         .idle     (w_idle)
      );

      assign frame_len[i*LEN_W +: LEN_W]     = r_act_frame;
      assign blank_len[i*LEN_W +: LEN_W]     = r_act_blank;
      assign rdaddr_begin[i*ADDR_W +: ADDR_W] = r_act_rbeg;
      assign rdaddr_end[i*ADDR_W +: ADDR_W]   = r_act_rend;
      assign cfg_err[i]                       = r_cfg_err;
   end

endmodule

`default_nettype wire
